regfile_alu_sequencer: RTL and testbench

Sequencer and execute stage that sits directly downstream of the 8x16 register file and also drives its ports.
- Per `start` command, it reads two source registers over two cycles through the file's combinational read port.
- It shifts the second operand, performs an ALU op and latches result and status flags.
- It writes the result back to a destination register, then pulses `done`.

---
 rtl/regfile_alu_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_regfile_alu_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_alu_sequencer.sv
// Command sequencer and execute stage for an 8x16 register file.
// For each accepted start it reads two source registers through the file's
// combinational read port, shifts B, runs the ALU, latches the result and flags,
// writes the result back, and then pulses done.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              command request (sampled in IDLE only)
//   opcode, shift      ALU op (ADD/SUB/AND/NOT B), shift applied to B
//   rn, rm, rd         source A, source B, destination register indices
//   rf_data_out        register file read data (combinational from rf_readnum)
//   rf_readnum         register file read index
//   rf_writenum/rf_write/rf_data_in  register file write port
//   busy, done         command in progress / one-cycle completion pulse
//   z_flag, n_flag, v_flag  zero, negative, signed overflow of the last result
module regfile_alu_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        opcode,
  input  logic [1:0]        shift,
  input  logic [ADDR_W-1:0] rn,
  input  logic [ADDR_W-1:0] rm,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] rf_data_out,
  output logic [ADDR_W-1:0] rf_readnum,
  output logic [ADDR_W-1:0] rf_writenum,
  output logic              rf_write,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              busy,
  output logic              done,
  output logic              z_flag,
  output logic              n_flag,
  output logic              v_flag
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  localparam logic [1:0] SH_LSL = 2'b01;
  localparam logic [1:0] SH_LSR = 2'b10;
  localparam logic [1:0] SH_ASR = 2'b11;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        opcode_q, opcode_d;
  logic [1:0]        shift_q, shift_d;
  logic [ADDR_W-1:0] rm_q, rm_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic              z_q, z_d;
  logic              n_q, n_d;
  logic              v_q, v_d;
  logic [ADDR_W-1:0] readnum_q, readnum_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] bs_c;
  logic [DATA_W-1:0] alu_c;
  logic              ovf_c;

  // Barrel-free single-bit shifter on operand B
  always_comb begin
    bs_c = b_q;
    case (shift_q)
      SH_LSL:  bs_c = {b_q[DATA_W-2:0], 1'b0};
      SH_LSR:  bs_c = {1'b0, b_q[DATA_W-1:1]};
      SH_ASR:  bs_c = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: bs_c = b_q;
    endcase
  end

  // ALU result and signed overflow
  always_comb begin
    alu_c = '0;
    ovf_c = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        alu_c = a_q + bs_c;
        ovf_c = (a_q[DATA_W-1] == bs_c[DATA_W-1]) && (alu_c[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_SUB: begin
        alu_c = a_q - bs_c;
        ovf_c = (a_q[DATA_W-1] != bs_c[DATA_W-1]) && (alu_c[DATA_W-1] != a_q[DATA_W-1]);
      end
      OP_AND:  alu_c = a_q & bs_c;
      default: alu_c = ~bs_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    shift_d   = shift_q;
    rm_d      = rm_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    z_d       = z_q;
    n_d       = n_q;
    v_d       = v_q;
    readnum_d = readnum_q;
    busy_d    = busy_q;
    write_d   = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d  = opcode;
          shift_d   = shift;
          rm_d      = rm;
          rd_d      = rd;
          // rn only matters for the first read, so it goes straight to the port
          readnum_d = rn;
          busy_d    = 1'b1;
          state_d   = RD_A;
        end
      end
      RD_A: begin
        a_d       = rf_data_out;
        readnum_d = rm_q;
        state_d   = RD_B;
      end
      RD_B: begin
        b_d     = rf_data_out;
        state_d = EXEC;
      end
      EXEC: begin
        c_d     = alu_c;
        z_d     = (alu_c == '0);
        n_d     = alu_c[DATA_W-1];
        v_d     = ovf_c;
        write_d = 1'b1;
        state_d = WB;
      end
      WB: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also kills any pending write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      shift_q   <= '0;
      rm_q      <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      z_q       <= 1'b0;
      n_q       <= 1'b0;
      v_q       <= 1'b0;
      readnum_q <= '0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      shift_q   <= shift_d;
      rm_q      <= rm_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      n_q       <= n_d;
      v_q       <= v_d;
      readnum_q <= readnum_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rf_readnum  = readnum_q;
  assign rf_writenum = rd_q;
  assign rf_data_in  = c_q;
  assign rf_write    = write_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign z_flag      = z_q;
  assign n_flag      = n_q;
  assign v_flag      = v_q;

endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// Bench for regfile_alu_sequencer: behavioural 8x16 register file, directed
// commands, cycle-by-cycle timeline checks and a write-back scoreboard.
module tb_regfile_alu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  opcode;
  logic [1:0]  shift;
  logic [2:0]  rn;
  logic [2:0]  rm;
  logic [2:0]  rd;
  logic [15:0] rf_data_out;
  logic [2:0]  rf_readnum;
  logic [2:0]  rf_writenum;
  logic        rf_write;
  logic [15:0] rf_data_in;
  logic        busy;
  logic        done;
  logic        z_flag;
  logic        n_flag;
  logic        v_flag;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        z;
    logic        n;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Register file model with a backdoor load port
  logic [15:0] regs [8];
  logic        bd_we;
  logic [2:0]  bd_addr;
  logic [15:0] bd_data;

  always @(posedge clk) begin
    if (rf_write) regs[rf_writenum] <= rf_data_in;
    if (bd_we) regs[bd_addr] <= bd_data;
  end
  assign rf_data_out = regs[rf_readnum];

  regfile_alu_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .shift(shift),
    .rn(rn), .rm(rm), .rd(rd), .rf_data_out(rf_data_out),
    .rf_readnum(rf_readnum), .rf_writenum(rf_writenum), .rf_write(rf_write),
    .rf_data_in(rf_data_in), .busy(busy), .done(done),
    .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [1:0] sh, input logic [15:0] a,
                       input logic [15:0] b, input logic [2:0] dst, output exp_t e);
    logic [15:0] bs;
    logic [16:0] wide;
    int sa, sb_i, sr;
    case (sh)
      2'b01:   bs = b << 1;
      2'b10:   bs = b >> 1;
      2'b11:   bs = 16'($signed(b) >>> 1);
      default: bs = b;
    endcase
    sa = int'($signed(a));
    sb_i = int'($signed(bs));
    e.v = 1'b0;
    case (op)
      2'b00: begin
        wide = 17'(a) + 17'(bs);
        e.data = wide[15:0];
        sr = sa + sb_i;
        e.v = (sr > 32767) || (sr < -32768);
      end
      2'b01: begin
        e.data = a - bs;
        sr = sa - sb_i;
        e.v = (sr > 32767) || (sr < -32768);
      end
      2'b10:   e.data = a & bs;
      default: e.data = ~bs;
    endcase
    e.addr = dst;
    e.z = (e.data == 16'h0);
    e.n = e.data[15];
  endtask

  // Backdoor load; starts and ends at a falling edge
  task automatic poke(input logic [2:0] a, input logic [15:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1 bd_we = 1'b0;
    @(negedge clk);
  endtask

  // One command from issue to the cycle after done. mask[i] drives start at
  // the i-th falling edge after acceptance, to probe that busy-time starts are ignored.
  task automatic run(input logic [1:0] op, input logic [1:0] sh, input logic [2:0] n,
                     input logic [2:0] m, input logic [2:0] d, input logic [5:0] mask);
    exp_t e, got;
    int nw, nd;
    model(op, sh, regs[n], regs[m], d, e);
    sb.push_back(e);
    opcode = op; shift = sh; rn = n; rm = m; rd = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    opcode = 2'($urandom); shift = 2'($urandom);
    rn = 3'($urandom); rm = 3'($urandom); rd = 3'($urandom);
    nw = 0; nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = mask[i];
      chk($sformatf("busy[%0d]", i), 16'(busy), 16'(i < 4));
      chk($sformatf("done[%0d]", i), 16'(done), 16'(i == 4));
      chk($sformatf("write[%0d]", i), 16'(rf_write), 16'(i == 3));
      chk($sformatf("readnum[%0d]", i), 16'(rf_readnum), 16'((i == 0) ? n : m));
      if (done === 1'b1) nd++;
      if (rf_write === 1'b1) begin
        nw++;
        if (sb.size() == 0) begin
          chk("sb_underflow", 16'(sb.size()), 16'd1);
        end else begin
          got = sb.pop_front();
          chk("wb_addr", 16'(rf_writenum), 16'(got.addr));
          chk("wb_data", rf_data_in, got.data);
          chk("z_flag", 16'(z_flag), 16'(got.z));
          chk("n_flag", 16'(n_flag), 16'(got.n));
          chk("v_flag", 16'(v_flag), 16'(got.v));
        end
      end
    end
    chk("write_count", 16'(nw), 16'd1);
    chk("done_count", 16'(nd), 16'd1);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    chk("reg_dst", regs[d], e.data);
    chk("flags_hold", 16'({z_flag, n_flag, v_flag}), 16'({e.z, e.n, e.v}));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 16'(busy), 16'd0);
    chk({tag, "_done"}, 16'(done), 16'd0);
    chk({tag, "_write"}, 16'(rf_write), 16'd0);
    chk({tag, "_readnum"}, 16'(rf_readnum), 16'd0);
    chk({tag, "_writenum"}, 16'(rf_writenum), 16'd0);
    chk({tag, "_data_in"}, rf_data_in, 16'd0);
    chk({tag, "_flags"}, 16'({z_flag, n_flag, v_flag}), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = '0; shift = '0;
    rn = '0; rm = '0; rd = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    @(negedge clk);
    poke(3'd0, 16'd512);
    poke(3'd1, 16'd1020);
    poke(3'd2, 16'h1111);
    poke(3'd3, 16'h7FFF);
    poke(3'd4, 16'd5);
    poke(3'd5, 16'd10);
    poke(3'd6, 16'h2222);
    poke(3'd7, 16'h0001);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Reset asserted during EXEC of an ADD aborts it with no write-back
    opcode = 2'b00; shift = 2'b00; rn = 3'd0; rm = 3'd1; rd = 3'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_abort_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("abort");
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_r2", regs[2], 16'h1111);
    chk("abort_idle_busy", 16'(busy), 16'd0);

    // ADD R2 = R0 + R1
    run(2'b00, 2'b00, 3'd0, 3'd1, 3'd2, 6'b000000);
    chk("r2_1532", regs[2], 16'd1532);

    // SUB R6 = R4 - (R5 >> 1) = 0
    run(2'b01, 2'b10, 3'd4, 3'd5, 3'd6, 6'b000000);

    // ADD overflow with start held high; second command accepted at k+6
    run(2'b00, 2'b00, 3'd3, 3'd7, 3'd3, 6'b111111);
    chk("r3_8000", regs[3], 16'h8000);
    run(2'b10, 2'b00, 3'd3, 3'd7, 3'd1, 6'b000000);

    // NOT (R1 << 1)
    poke(3'd1, 16'h00FF);
    run(2'b11, 2'b01, 3'd2, 3'd1, 3'd0, 6'b000000);
    chk("r0_fe01", regs[0], 16'hFE01);

    // ASR sign replication: R4 = 0 + asr(0x8002)
    poke(3'd5, 16'h0000);
    poke(3'd2, 16'h8002);
    run(2'b00, 2'b11, 3'd5, 3'd2, 3'd4, 6'b000000);
    chk("r4_c001", regs[4], 16'hC001);

    // Starts pulsed in RD_B, EXEC and DONE are ignored; rd aliases rn
    poke(3'd0, 16'd5);
    poke(3'd2, 16'd6);
    run(2'b10, 2'b00, 3'd0, 3'd2, 3'd0, 6'b010110);
    chk("r0_4", regs[0], 16'd4);
    repeat (3) @(negedge clk);
    chk("idle_after_pulses", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
